// File: rtl/resource_arbiter.sv
// resource_arbiter: round-robin arbiter in front of a fixed-latency shared
// resource. A grant in cycle t issues the winner's data in t+1. The result is
// sampled RES_LAT cycles after issue and returned to the winning requester one
// cycle later. flush or reset discards every in-flight transaction silently.
module resource_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int RES_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        arb_req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    arb_enable,
  input  logic                    flush,
  output logic [N_REQ-1:0]        arb_grant,
  output logic                    res_in_valid,
  output logic [DATA_W-1:0]       res_in_data,
  input  logic [DATA_W-1:0]       res_out_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // round-robin pointer: first index searched on the next arbitration
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;

  // combinational arbitration result
  logic [N_REQ-1:0] grant;
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;

  // issue register feeding the resource
  logic             iss_valid_reg;
  logic [IDX_W-1:0] iss_idx_reg;
  logic [DATA_W-1:0] iss_data_reg;

  // in-flight tracking: stage RES_LAT-1 lines up with res_out_data
  logic [RES_LAT-1:0] pipe_valid_reg;
  logic [IDX_W-1:0]   pipe_idx_reg [RES_LAT];

  // response register
  logic              rsp_valid_reg;
  logic [IDX_W-1:0]  rsp_idx_reg;
  logic [DATA_W-1:0] rsp_data_reg;

  // search ptr, ptr+1, ... (mod N_REQ); grants are suppressed in reset, flush and disable
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (reset && arb_enable && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = IDX_W'((int'(ptr_reg) + k) % N_REQ);
        if (!gnt_any && arb_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_any) begin
        grant[gnt_idx] = 1'b1;
      end
    end
  end

  // pointer moves just past the winner; N_REQ need not be a power of two
  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_any) begin
      ptr_next = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // capture the granted slice; data holds when nothing is issued
  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_valid_reg <= 1'b0;
      iss_idx_reg   <= '0;
      iss_data_reg  <= '0;
    end else begin
      iss_valid_reg <= gnt_any && !flush;
      if (gnt_any) begin
        iss_idx_reg  <= gnt_idx;
        iss_data_reg <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
      end
    end
  end

  // shift valid/index alongside the resource latency; flush kills every stage
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= iss_valid_reg;
      for (int k = RES_LAT - 1; k > 0; k--) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
      end
    end
  end

  // index travels with the valid bit; it is meaningless while the bit is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < RES_LAT; k++) begin
        pipe_idx_reg[k] <= '0;
      end
    end else begin
      pipe_idx_reg[0] <= iss_idx_reg;
      for (int k = RES_LAT - 1; k > 0; k--) begin
        pipe_idx_reg[k] <= pipe_idx_reg[k-1];
      end
    end
  end

  // sample the resource result on the cycle it is valid; data holds otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_idx_reg   <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= pipe_valid_reg[RES_LAT-1] && !flush;
      if (pipe_valid_reg[RES_LAT-1] && !flush) begin
        rsp_idx_reg  <= pipe_idx_reg[RES_LAT-1];
        rsp_data_reg <= res_out_data;
      end
    end
  end

  // one-hot response strobe toward the owning requester
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = rsp_valid_reg && (rsp_idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign arb_grant    = grant;
  assign res_in_valid = iss_valid_reg;
  assign res_in_data  = iss_data_reg;
  assign rsp_data     = rsp_data_reg;
  assign busy         = iss_valid_reg || (|pipe_valid_reg) || rsp_valid_reg;

endmodule

// File: tb/tb_resource_arbiter.sv
// tb_resource_arbiter: directed scenarios with a scoreboard. Each expected
// grant pushes the issue and response it must produce. A monitor pops and
// compares those entries on the cycle each one is due.
module tb_resource_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 32;
  localparam int RES_LAT = 2;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        arb_req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    arb_enable;
  logic                    flush;
  logic [N_REQ-1:0]        arb_grant;
  logic                    res_in_valid;
  logic [DATA_W-1:0]       res_in_data;
  logic [DATA_W-1:0]       res_out_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    busy;

  int cyc;
  int tests_run;
  int tests_failed;

  typedef struct {
    int                due;
    logic [N_REQ-1:0]  onehot;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t iss_q[$];
  ent_t rsp_q[$];

  resource_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .RES_LAT(RES_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arb_req     (arb_req),
    .req_data    (req_data),
    .arb_enable  (arb_enable),
    .flush       (flush),
    .arb_grant   (arb_grant),
    .res_in_valid(res_in_valid),
    .res_in_data (res_in_data),
    .res_out_data(res_out_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // resource model: output value encodes the cycle it is presented in
  assign res_out_data = {16'hBE00, cyc[15:0]};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("[TB] ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // drive one cycle, check the grant, and queue the expected issue/response
  task automatic step(input logic rst_n, input logic [N_REQ-1:0] req, input logic en,
                      input logic fl, input logic [N_REQ-1:0] exp_g);
    ent_t e;
    int   idx;
    reset      = rst_n;
    arb_req    = req;
    arb_enable = en;
    flush      = fl;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
    @(negedge clk);
    check_eq("grant", 64'(arb_grant), 64'(exp_g));
    if (exp_g != '0) begin
      idx = 0;
      for (int i = 0; i < N_REQ; i++) if (exp_g[i]) idx = i;
      e.onehot = exp_g;
      e.due    = cyc + 1;
      e.data   = req_data[idx*DATA_W +: DATA_W];
      iss_q.push_back(e);
      e.due    = cyc + 2 + RES_LAT;
      e.data   = {16'hBE00, 16'(cyc + 1 + RES_LAT)};
      rsp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl || !rst_n) begin
      iss_q.delete();
      rsp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 1'b1, 1'b0, '0);
  endtask

  // monitor: every due entry must appear on time; nothing else may appear
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        e = iss_q.pop_front();
        check_eq("iss_valid", 64'(res_in_valid), 64'd1);
        check_eq("iss_data", 64'(res_in_data), 64'(e.data));
      end else if (res_in_valid === 1'b1) begin
        check_eq("iss_unexpected", 64'(res_in_valid), 64'd0);
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        e = rsp_q.pop_front();
        check_eq("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
        check_eq("rsp_data", 64'(rsp_data), 64'(e.data));
      end else if (rsp_valid !== '0 && rsp_valid !== 'x) begin
        check_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end
    end
  end

  initial begin
    cyc          = 0;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    arb_req      = '0;
    arb_enable   = 1'b1;
    flush        = 1'b0;
    req_data     = '0;
    @(posedge clk);
    #1;

    // reset: no grant even with requests pending; all state cleared
    step(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000);
    step(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000);
    check_eq("rst_res_in_valid", 64'(res_in_valid), 64'd0);
    check_eq("rst_res_in_data", 64'(res_in_data), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // single request to index 2 from ptr=0; ptr becomes 3
    step(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100);
    check_eq("busy_inflight", 64'(busy), 64'd1);
    idle(5);
    check_eq("busy_drained", 64'(busy), 64'd0);

    // from ptr=3 grant 0 (ptr=1), again 0 (ptr stays 1), then 3 over 0
    step(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
    step(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
    step(1'b1, 4'b1001, 1'b1, 1'b0, 4'b1000);
    idle(5);

    // full contention from reset: 0,1,2,3,0,1,2,3 back to back
    step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000);
    for (int r = 0; r < 8; r++) step(1'b1, 4'b1111, 1'b1, 1'b0, 4'(1 << (r % 4)));
    idle(6);

    // disable holds ptr=1; re-enable grants index 1
    step(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
    idle(5);
    for (int r = 0; r < 3; r++) step(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0010);
    idle(5);

    // flush after grants to 0 and 1: no responses, ptr=2 preserved
    step(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
    step(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010);
    step(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000);
    check_eq("flush_busy", 64'(busy), 64'd0);
    step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0100);
    idle(5);

    // reset mid-flight: both transactions dropped; ptr back to 0
    step(1'b1, 4'b1000, 1'b1, 1'b0, 4'b1000);
    step(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000);
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    step(1'b1, 4'b0011, 1'b1, 1'b0, 4'b0001);
    idle(6);

    check_eq("final_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check_eq("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/resource_arbiter.md
RESOURCE_ARBITER -- requirements
Module: resource_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of pipeline requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, request/response data width.
REQ-003 SHALL have parameter RES_LAT, default 2, fixed shared-resource latency in cycles (1..8).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
REQ-006 SHALL have port arb_req  input  N_REQ  per-requester request, bit i from requester i's arbiter_req.
REQ-007 SHALL have port req_data  input  N_REQ*DATA_W  flat request data, slice i = [i*DATA_W +: DATA_W].
REQ-008 SHALL have port arb_enable  input  1  1 = grants allowed; 0 = no grants.
REQ-009 SHALL have port flush  input  1  discard all in-flight transactions.
REQ-010 SHALL have port arb_grant  output  N_REQ  one-hot-or-zero grant, bit i to requester i's arbiter_grant.
REQ-011 SHALL have port res_in_valid  output  1  transaction issued to resource this cycle.
REQ-012 SHALL have port res_in_data  output  DATA_W  data issued to resource.
REQ-013 SHALL have port res_out_data  input  DATA_W  resource result, valid exactly RES_LAT cycles after issue.
REQ-014 SHALL have port rsp_valid  output  N_REQ  one-hot-or-zero response strobe to requester i.
REQ-015 SHALL have port rsp_data  output  DATA_W  response data, broadcast to all requesters.
REQ-016 SHALL have port busy  output  1  1 while any transaction is in flight.

Function
REQ-017 SHALL compute arb_grant combinationally from arb_req, arb_enable, flush and a registered round-robin pointer ptr.
REQ-018 SHALL grant the first requester with arb_req=1 searching ptr, ptr+1, ... wrapping mod N_REQ; at most one grant bit high.
REQ-019 SHALL drive arb_grant=0 when arb_enable=0, flush=1, or no request is active.
REQ-020 SHALL update ptr to (granted index + 1) mod N_REQ on any granting cycle; ptr holds otherwise, including during flush.
REQ-021 SHALL, for a grant to i in cycle t, register req_data slice i so that res_in_valid=1 and res_in_data=that slice in cycle t+1; res_in_valid=0 in cycles following no grant.
REQ-022 SHALL hold res_in_data at its last value when res_in_valid=0.
REQ-023 SHALL carry a valid bit plus requester index through a RES_LAT-deep in-flight shift register aligned to res_in_valid.
REQ-024 SHALL, in cycle t+1+RES_LAT, sample res_out_data and in cycle t+2+RES_LAT assert rsp_valid[i]=1 for exactly one cycle with rsp_data = sampled value.
REQ-025 SHALL sustain one issue per cycle (back-to-back grants), responses returning in issue order, one per cycle.
REQ-026 SHALL, when flush=1, clear every in-flight valid bit, the issue register valid, and the response register valid on that edge; no rsp_valid for any transaction granted before or during the flush cycle.
REQ-027 SHALL hold rsp_data at its last value when rsp_valid=0.
REQ-028 SHALL drive busy = OR of issue-register valid, all in-flight valid bits and the response-register valid.
REQ-029 SHALL ignore req_data slices of non-granted requesters; a request dropped before grant is never issued.

Reset
REQ-030 SHALL, with reset=0 at a clk edge, set ptr=0, all in-flight valid bits 0, res_in_valid=0, rsp_valid=0, busy=0, res_in_data=0, rsp_data=0.
REQ-031 SHALL, during reset=0, drive arb_grant=0 regardless of arb_req.
REQ-032 SHALL, on reset mid-operation, drop all in-flight transactions silently; first grant after release goes to lowest active index from ptr=0.

Verification
REQ-033 Single request: ptr=0, arb_req=4'b0100, req_data[2]=32'hA5A5_0001, RES_LAT=2 -> arb_grant=4'b0100 cycle t, res_in_valid t+1 with 32'hA5A5_0001; resource returns 32'h1234 at t+3 -> rsp_valid=4'b0100, rsp_data=32'h1234 at t+4; ptr=3.
REQ-034 Full contention: arb_req=4'b1111 held 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3, one per cycle; rsp_valid follows same order, back-to-back.
REQ-035 Skip idle: ptr=1, arb_req=4'b0001 -> grant 4'b0001, ptr becomes 1; then arb_req=4'b1001 -> grant 4'b1000.
REQ-036 Flush: grants to 0 and 1 in consecutive cycles, flush=1 one cycle later -> no rsp_valid ever for either, busy=0 next cycle, ptr=2 preserved.
REQ-037 arb_enable=0 with arb_req=4'b1111 for 3 cycles -> arb_grant=0, res_in_valid=0, ptr unchanged; re-enable -> grant resumes at ptr.
REQ-038 Reset mid-flight: two transactions in flight, reset=0 for one cycle -> rsp_valid stays 0, busy=0, ptr=0 after release.
